// File: rtl/jpeg_rle_if.sv
// Quantized-coefficient input and RLE symbol output bundle for jpeg_rle.
// master = coefficient source / symbol sink, slave = the RLE block.
interface jpeg_rle_if #(parameter int QW = 11);
    logic signed [QW-1:0] q [2];
    logic                 q_valid;
    logic                 q_hold;
    logic [4:0]           q_cnt;
    logic [1:0]           q_chroma;
    logic                 q_last_mcu;
    logic                 s_valid;
    logic                 s_hold;
    logic                 s_dc;
    logic [3:0]           s_run;
    logic [3:0]           s_size;
    logic [QW-1:0]        s_amp;
    logic [1:0]           s_chroma;
    logic                 s_last;

    modport master (
        output q, q_valid, q_cnt, q_chroma, q_last_mcu, s_hold,
        input  q_hold, s_valid, s_dc, s_run, s_size, s_amp, s_chroma, s_last
    );

    modport slave (
        input  q, q_valid, q_cnt, q_chroma, q_last_mcu, s_hold,
        output q_hold, s_valid, s_dc, s_run, s_size, s_amp, s_chroma, s_last
    );
endinterface

// File: rtl/jpeg_rle.sv
// JPEG DC differential + AC run-length coder, one symbol per cycle.
// Define RLE_STAT_EN to add the frame_syms per-frame symbol count output.
module jpeg_rle #(
    parameter int QW = 11
) (
    input  logic        clk,
    input  logic        reset,
    jpeg_rle_if.slave   bus
`ifdef RLE_STAT_EN
    ,
    output logic [19:0] frame_syms
`endif
);
    typedef enum logic [1:0] {IDLE, COEF, ZRL, EOB} state_t;

    if (QW != 11) begin : g_qw_check
        $error("jpeg_rle: only QW=11 is supported");
    end

    function automatic logic [3:0] cat(input logic signed [11:0] v);
        logic [11:0] m;
        m = v[11] ? -v : v;
        cat = 4'd0;
        for (int i = 0; i < 12; i++)
            if (m[i]) cat = 4'(i + 1);
    endfunction

    function automatic logic [10:0] ampf(input logic signed [11:0] v,
                                         input logic [3:0] n);
        logic [11:0] t;
        t = v[11] ? v - 12'sd1 : v;
        return t[10:0] & ~(11'h7FF << n);
    endfunction

    state_t               state, nstate;
    logic signed [QW-1:0] buf_q0, buf_q1;
    logic [4:0]           buf_cnt;
    logic [1:0]           buf_chroma;
    logic                 buf_last, buf_full, pos;
    logic [5:0]           run, run_n;
    logic signed [QW-1:0] pred [3];
    logic [1:0]           blk_chroma, pidx;
    logic                 blk_last;
    logic                 adv, xfer, s_xfer, consume, emit, pred_wr;
    logic                 e_dc, e_last;
    logic [3:0]           e_run, sz;
    logic [10:0]          am;
    logic [1:0]           e_chroma;
    logic [5:0]           idx;
    logic                 is_dc;
    logic signed [QW-1:0] cur, p_sel;
    logic signed [11:0]   val;

    assign adv      = !bus.s_valid || !bus.s_hold;
    assign s_xfer   = bus.s_valid && !bus.s_hold;
    assign bus.q_hold = buf_full && !(pos && consume);
    assign xfer     = bus.q_valid && !bus.q_hold;
    assign idx      = {buf_cnt, pos};
    assign is_dc    = (idx == 6'd0);
    assign cur      = pos ? buf_q1 : buf_q0;
    assign pidx     = (buf_chroma == 2'd3) ? 2'd0 : buf_chroma;

    // Predictors read as zero while the frame-final symbol leaves
    always_comb begin
        p_sel = pred[pidx];
        if (s_xfer && bus.s_last) p_sel = '0;
        val = is_dc ? {cur[10], cur} - {p_sel[10], p_sel}
                    : {cur[10], cur};
    end

    assign sz = cat(val);
    assign am = ampf(val, sz);

    always_comb begin
        nstate   = state;
        emit     = 1'b0;
        e_dc     = 1'b0;
        e_run    = 4'd0;
        e_chroma = buf_chroma;
        e_last   = 1'b0;
        consume  = 1'b0;
        run_n    = run;
        pred_wr  = 1'b0;
        unique case (state)
            IDLE: if (xfer) nstate = COEF;
            COEF, ZRL: if (adv) begin
                if (is_dc) begin
                    emit    = 1'b1;
                    e_dc    = 1'b1;
                    consume = 1'b1;
                    pred_wr = 1'b1;
                    run_n   = 6'd0;
                end else if (cur == '0) begin
                    consume = 1'b1;
                    run_n   = run + 6'd1;
                end else if (run >= 6'd16) begin
                    emit   = 1'b1;
                    e_run  = 4'd15;
                    run_n  = run - 6'd16;
                    nstate = ZRL;
                end else begin
                    emit    = 1'b1;
                    e_run   = run[3:0];
                    e_last  = (idx == 6'd63) && buf_last && (buf_chroma == 2'd2);
                    consume = 1'b1;
                    run_n   = 6'd0;
                end
                if (consume) begin
                    if (idx == 6'd63 && run_n != 6'd0) nstate = EOB;
                    else if (pos) nstate = xfer ? COEF : IDLE;
                    else nstate = COEF;
                end
            end
            EOB: if (adv) begin
                emit     = 1'b1;
                e_chroma = blk_chroma;
                e_last   = blk_last;
                run_n    = 6'd0;
                nstate   = (buf_full || xfer) ? COEF : IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            run          <= '0;
            buf_q0       <= '0;
            buf_q1       <= '0;
            buf_cnt      <= '0;
            buf_chroma   <= '0;
            buf_last     <= 1'b0;
            buf_full     <= 1'b0;
            pos          <= 1'b0;
            pred         <= '{default: '0};
            blk_chroma   <= '0;
            blk_last     <= 1'b0;
            bus.s_valid  <= 1'b0;
            bus.s_dc     <= 1'b0;
            bus.s_run    <= '0;
            bus.s_size   <= '0;
            bus.s_amp    <= '0;
            bus.s_chroma <= '0;
            bus.s_last   <= 1'b0;
        end else begin
            state <= nstate;
            run   <= run_n;
            if (adv) begin
                bus.s_valid  <= emit;
                bus.s_dc     <= e_dc;
                bus.s_run    <= e_run;
                bus.s_size   <= (emit && e_run != 4'd15 && state != EOB) ? sz : 4'd0;
                bus.s_amp    <= (emit && e_run != 4'd15 && state != EOB) ? am : 11'd0;
                bus.s_chroma <= e_chroma;
                bus.s_last   <= e_last;
            end
            if (consume) begin
                if (pos) buf_full <= 1'b0;
                else pos <= 1'b1;
                if (idx == 6'd63) begin
                    blk_chroma <= buf_chroma;
                    blk_last   <= buf_last && (buf_chroma == 2'd2);
                end
            end
            if (s_xfer && bus.s_last) pred <= '{default: '0};
            if (pred_wr) pred[pidx] <= cur;
            if (xfer) begin
                buf_q0     <= bus.q[0];
                buf_q1     <= bus.q[1];
                buf_cnt    <= bus.q_cnt;
                buf_chroma <= bus.q_chroma;
                buf_last   <= bus.q_last_mcu;
                buf_full   <= 1'b1;
                pos        <= 1'b0;
            end
        end
    end

`ifdef RLE_STAT_EN
    logic [19:0] sym_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt    <= '0;
            frame_syms <= '0;
        end else if (s_xfer) begin
            if (bus.s_last) begin
                frame_syms <= sym_cnt + 20'd1;
                sym_cnt    <= '0;
            end else begin
                sym_cnt <= sym_cnt + 20'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    logic [4:0] exp_cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_cnt <= '0;
        end else if (xfer) begin
            assert (bus.q_cnt == exp_cnt)
                else $error("jpeg_rle: q_cnt %0d out of sequence", bus.q_cnt);
            exp_cnt <= bus.q_cnt + 5'd1;
        end
    end
`endif
endmodule
